deca_vip_status_pio_edge: RTL and testbench

- Parametrised successor to the fixed 4-bit input-only status PIO on the Avalon-MM control bus.
- Samples WIDTH asynchronous status inputs (DDR3 calibration, PLL lock, etc.) through a configurable synchroniser.
- Provides a level-read register, per-bit edge capture with write-1-to-clear, an interrupt mask and a level interrupt output to the Nios II.
- Read latency is a fixed 1 cycle, matching existing PIO slaves.

---
 rtl/deca_vip_status_pio_edge.sv | 148 ++++++++++++++
 tb/tb_deca_vip_status_pio_edge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/deca_vip_status_pio_edge.sv
// Avalon-MM status PIO: synchronised level read, per-bit edge capture with W1C,
// interrupt mask and registered level interrupt. Read latency is one cycle.
module deca_vip_status_pio_edge #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0,
   parameter int IRQ_EN      = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [2:0] ARM_MAX  = 3'(SYNC_STAGES + 1);
   localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q_s;
   logic [WIDTH-1:0] prev_r;
   logic [2:0]       arm_r;
   logic [WIDTH-1:0] edge_capture_r;
   logic [WIDTH-1:0] irq_mask_r;
   logic             irq_r;
   logic [31:0]      readdata_r;

   logic             wr_s;
   logic [WIDTH-1:0] w1c_s;
   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] det_s;
   logic [31:0]      rd_mux_s;
   logic             unused_wdata_s;

   assign sync_q_s       = sync_r[SYNC_STAGES-1];
   assign unused_wdata_s = ^writedata;
   assign readdata       = readdata_r;
   assign irq            = irq_r;

   // Synchroniser chain for the asynchronous status inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         sync_r[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // Previous synchronised sample and post-reset arm counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_r <= {WIDTH{1'b0}};
         arm_r  <= 3'd0;
      end else begin
         prev_r <= sync_q_s;
         if (arm_r < ARM_MAX) begin
            arm_r <= arm_r + 3'd1;
         end
      end
   end

   // Write strobe decode and write-1-to-clear vector
   always_comb begin
      wr_s  = chipselect & ~write_n;
      w1c_s = {WIDTH{1'b0}};
      if (wr_s && (address == 2'd3)) begin
         w1c_s = writedata[WIDTH-1:0];
      end else begin
         w1c_s = {WIDTH{1'b0}};
      end
   end

   // Edge selection, suppressed until the sync chain has filled after reset
   always_comb begin
      rise_s = sync_q_s & ~prev_r;
      fall_s = ~sync_q_s & prev_r;
      case (EDGE_SEL)
         2'd0:    edge_s = rise_s;
         2'd1:    edge_s = fall_s;
         2'd2:    edge_s = rise_s | fall_s;
         default: edge_s = rise_s;
      endcase
      if (arm_r < ARM_MAX) begin
         det_s = {WIDTH{1'b0}};
      end else begin
         det_s = edge_s;
      end
   end

   // Edge capture: a new edge wins over a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_capture_r <= {WIDTH{1'b0}};
      end else begin
         edge_capture_r <= (edge_capture_r & ~w1c_s) | det_s;
      end
   end

   // Interrupt mask register, held at zero when the interrupt is not built
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask_r <= {WIDTH{1'b0}};
      end else if (wr_s && (address == 2'd2) && (IRQ_EN != 0)) begin
         irq_mask_r <= writedata[WIDTH-1:0];
      end
   end

   // Registered level interrupt
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= (IRQ_EN != 0) ? |(edge_capture_r & irq_mask_r) : 1'b0;
      end
   end

   // Read mux, independent of chipselect
   always_comb begin
      case (address)
         2'd0:    rd_mux_s = 32'(sync_q_s);
         2'd1:    rd_mux_s = 32'd0;
         2'd2:    rd_mux_s = 32'(irq_mask_r);
         2'd3:    rd_mux_s = 32'(edge_capture_r);
         default: rd_mux_s = 32'd0;
      endcase
   end

   // One-cycle registered read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata_r <= 32'd0;
      end else begin
         readdata_r <= rd_mux_s;
      end
   end

endmodule

// File: tb/tb_deca_vip_status_pio_edge.sv
// Directed bench: three instances cover rising (4-bit), any-edge (8-bit) and
// falling with irq disabled and a 3-stage synchroniser.
module tb_deca_vip_status_pio_edge;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic        cs0, cs1, cs2;
   logic [3:0]  in0;
   logic [7:0]  in1;
   logic [3:0]  in2;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   deca_vip_status_pio_edge #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_EN(1)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs0), .write_n(write_n),
      .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));

   deca_vip_status_pio_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_EN(1)) dut1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs1), .write_n(write_n),
      .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));

   deca_vip_status_pio_edge #(.WIDTH(4), .SYNC_STAGES(3), .EDGE_TYPE(1), .IRQ_EN(0)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs2), .write_n(write_n),
      .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input int which);
      address   = a;
      writedata = d;
      write_n   = 1'b0;
      cs0       = (which == 0);
      cs1       = (which == 1);
      cs2       = (which == 2);
      tick(1);
      write_n   = 1'b1;
      cs0       = 1'b0;
      cs1       = 1'b0;
      cs2       = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; in0 = 4'hF; in1 = 8'hFF; in2 = 4'hF; address = 2'd0;
      tick(2);
      checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL reset_rd0: got %h expected %h", rd0, 32'd0); end
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq0: got %b expected 0", irq0); end
      reset = 1'b0;
      tick(4);
      checks++; if (rd0 !== 32'h0000000F) begin errors++; $display("FAIL level_rd0: got %h expected %h", rd0, 32'hF); end
      checks++; if (rd1 !== 32'h000000FF) begin errors++; $display("FAIL level_rd1: got %h expected %h", rd1, 32'hFF); end
      checks++; if (rd2 !== 32'h0000000F) begin errors++; $display("FAIL level_rd2: got %h expected %h", rd2, 32'hF); end
      address = 2'd3;
      tick(1);
      checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL arm_cap0: got %h expected %h", rd0, 32'd0); end
      checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL arm_cap1: got %h expected %h", rd1, 32'd0); end
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL arm_irq0: got %b expected 0", irq0); end
   endtask

   task automatic test_rising;
      in0 = 4'h0;
      tick(5);
      checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL rise_ignore_fall: got %h expected %h", rd0, 32'd0); end
      in0 = 4'h5;
      tick(3);
      checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL rise_early: got %h expected %h", rd0, 32'd0); end
      tick(1);
      checks++; if (rd0 !== 32'h5) begin errors++; $display("FAIL rise_cap: got %h expected %h", rd0, 32'h5); end
      in0 = 4'h0;
      tick(6);
      checks++; if (rd0 !== 32'h5) begin errors++; $display("FAIL rise_hold: got %h expected %h", rd0, 32'h5); end
   endtask

   task automatic test_mask_irq;
      wr(2'd2, 32'h4, 0);
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", irq0); end
      tick(1);
      checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq0); end
      address = 2'd2;
      tick(1);
      checks++; if (rd0 !== 32'h4) begin errors++; $display("FAIL mask_read: got %h expected %h", rd0, 32'h4); end
      wr(2'd3, 32'h4, 0);
      checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_clear_latency: got %b expected 1", irq0); end
      tick(1);
      checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq0); end
      address = 2'd3;
      tick(1);
      checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL w1c_partial: got %h expected %h", rd0, 32'h1); end
   endtask

   task automatic test_set_priority;
      wr(2'd3, 32'h1, 0);
      address = 2'd3;
      tick(1);
      checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL w1c_bit0: got %h expected %h", rd0, 32'd0); end
      in0 = 4'h1;
      tick(2);
      wr(2'd3, 32'h1, 0);
      address = 2'd3;
      tick(1);
      checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL set_priority: got %h expected %h", rd0, 32'h1); end
      in0 = 4'h0;
   endtask

   task automatic test_any_edge;
      in1 = 8'h00;
      tick(5);
      address = 2'd3;
      tick(1);
      checks++; if (rd1 !== 32'hFF) begin errors++; $display("FAIL any_fall_all: got %h expected %h", rd1, 32'hFF); end
      wr(2'd3, 32'hFF, 1);
      tick(1);
      checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL any_clear: got %h expected %h", rd1, 32'd0); end
      in1 = 8'h80; tick(3); in1 = 8'h00; tick(5);
      checks++; if (rd1 !== 32'h80) begin errors++; $display("FAIL any_toggle1: got %h expected %h", rd1, 32'h80); end
      wr(2'd3, 32'h80, 1);
      tick(1);
      checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL any_clear2: got %h expected %h", rd1, 32'd0); end
      in1 = 8'h80; tick(3); in1 = 8'h00; tick(5);
      checks++; if (rd1 !== 32'h80) begin errors++; $display("FAIL any_toggle2: got %h expected %h", rd1, 32'h80); end
      address = 2'd1;
      tick(1);
      checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL reserved1: got %h expected %h", rd1, 32'd0); end
      checks++; if (rd0 !== 32'd0) begin errors++; $display("FAIL reserved0: got %h expected %h", rd0, 32'd0); end
   endtask

   task automatic test_falling;
      in2 = 4'h3;
      address = 2'd3;
      tick(4);
      checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL fall_early: got %h expected %h", rd2, 32'd0); end
      tick(1);
      checks++; if (rd2 !== 32'hC) begin errors++; $display("FAIL fall_cap: got %h expected %h", rd2, 32'hC); end
      wr(2'd2, 32'hF, 2);
      address = 2'd2;
      tick(1);
      checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL noirq_mask: got %h expected %h", rd2, 32'd0); end
      checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL noirq_irq: got %b expected 0", irq2); end
   endtask

   task automatic test_mid_reset;
      wr(2'd2, 32'hFF, 1);
      in1 = 8'hFF;
      tick(5);
      address = 2'd3;
      tick(1);
      checks++; if (rd1 !== 32'hFF) begin errors++; $display("FAIL pre_reset_cap: got %h expected %h", rd1, 32'hFF); end
      checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq1); end
      address = 2'd2;
      tick(1);
      checks++; if (rd1 !== 32'hFF) begin errors++; $display("FAIL pre_reset_mask: got %h expected %h", rd1, 32'hFF); end
      reset = 1'b1;
      #1;
      checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b expected 0", irq1); end
      checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL mid_reset_rd: got %h expected %h", rd1, 32'd0); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      address = 2'd2;
      tick(1);
      checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL post_reset_mask: got %h expected %h", rd1, 32'd0); end
      address = 2'd3;
      tick(5);
      checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL post_reset_cap: got %h expected %h", rd1, 32'd0); end
      checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b expected 0", irq1); end
   endtask

   initial begin
      reset = 1'b1; address = 2'd0; write_n = 1'b1; writedata = 32'd0;
      cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
      in0 = 4'h0; in1 = 8'h00; in2 = 4'h0;
      test_reset;
      test_rising;
      test_mask_irq;
      test_set_priority;
      test_any_edge;
      test_falling;
      test_mid_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
